// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcodes, control-unit state encoding, IR field layout.
package cpu_defs_pkg;

  // Opcode values held in IR[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;

  // IR field bit positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  // Sequencer states: RST=0, T0..T7=1..8, HALT=9
  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  // One-hot instruction class produced by instr_decode
  typedef struct packed {
    logic rtype;
    logic imm;
    logic ldi;
    logic ld;
    logic st;
    logic nop;
    logic halt;
  } instr_class_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: one-hot instruction class plus the ALU op used in T4.
module instr_decode
  import cpu_defs_pkg::*;
(
  input  logic [4:0]   i_opcode,
  output instr_class_t o_class,
  output logic [4:0]   o_alu_op
);

  // Classify the opcode; unknown opcodes fall into the nop class
  always_comb begin
    o_class  = '0;
    o_alu_op = ALU_NONE;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: begin
        o_class.rtype = 1'b1;
        o_alu_op      = i_opcode;
      end
      OP_ADDI: begin
        o_class.imm = 1'b1;
        o_alu_op    = OP_ADD;
      end
      OP_ANDI: begin
        o_class.imm = 1'b1;
        o_alu_op    = OP_AND;
      end
      OP_ORI: begin
        o_class.imm = 1'b1;
        o_alu_op    = OP_OR;
      end
      // Address/immediate forms all compute Rb (or 0) + C
      OP_LDI: begin
        o_class.ldi = 1'b1;
        o_alu_op    = OP_ADD;
      end
      OP_LD: begin
        o_class.ld = 1'b1;
        o_alu_op   = OP_ADD;
      end
      OP_ST: begin
        o_class.st = 1'b1;
        o_alu_op   = OP_ADD;
      end
      OP_HALT: o_class.halt = 1'b1;
      default: o_class.nop  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch T0-T2, execute T3-T7, register-transfer strobes.
module control_unit
  import cpu_defs_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        BAout,
  output logic        Cout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Rin,
  output logic        Rout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  ALU_op,
  output logic        Run,
  output logic [3:0]  o_state
);

  state_t       r_state;
  state_t       w_next;
  instr_class_t w_class;
  logic [4:0]   w_alu_op;
  logic         w_unused_ir;
  // After the final execute state: halt on Stop, otherwise fetch again
  state_t       w_done;

  // Register-select fields are consumed by the datapath, not here
  assign w_unused_ir = ^IR[RA_MSB:0];
  assign o_state     = r_state;
  assign w_done      = Stop ? S_HALT : S_T0;

  instr_decode u_decode (
    .i_opcode (IR[OPC_MSB:OPC_LSB]),
    .o_class  (w_class),
    .o_alu_op (w_alu_op)
  );

  // State register; Reset overrides every state including HALT
  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_RST;
    else       r_state <= w_next;
  end

  // Next-state and strobe decode from (state, opcode class)
  always_comb begin
    w_next  = r_state;
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    BAout   = 1'b0;
    Cout    = 1'b0;
    PCin    = 1'b0;
    MARin   = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    ALU_op  = ALU_NONE;
    Run     = (r_state != S_RST) && (r_state != S_HALT);
    case (r_state)
      S_RST: w_next = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        w_next = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        w_next = S_T3;
      end
      S_T3: begin
        if (w_class.halt)     w_next = S_HALT;
        else if (w_class.nop) w_next = w_done;
        else begin
          Grb = 1'b1; Yin = 1'b1;
          // Register-indexed forms read Rb; address forms use BAout (R0 reads as 0)
          if (w_class.rtype || w_class.imm) Rout  = 1'b1;
          else                              BAout = 1'b1;
          w_next = S_T4;
        end
      end
      S_T4: begin
        Zin    = 1'b1;
        ALU_op = w_alu_op;
        if (w_class.rtype) begin
          Grc = 1'b1; Rout = 1'b1;
        end else begin
          Cout = 1'b1;
        end
        w_next = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (w_class.ld || w_class.st) begin
          MARin  = 1'b1;
          w_next = S_T6;
        end else begin
          Gra = 1'b1; Rin = 1'b1;
          w_next = w_done;
        end
      end
      S_T6: begin
        MDRin = 1'b1;
        // ld fetches from memory; st loads MDR from Ra over the bus
        if (w_class.st) begin
          Gra = 1'b1; Rout = 1'b1;
        end else begin
          Read = 1'b1;
        end
        w_next = S_T7;
      end
      S_T7: begin
        if (w_class.st) Write = 1'b1;
        else begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
        w_next = w_done;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe vectors against hand-written expectations.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] IR;
  logic        Stop;
  logic        PCout, Zlowout, MDRout, BAout, Cout;
  logic        PCin, MARin, MDRin, IRin, Yin, Zin, Rin;
  logic        Rout, Gra, Grb, Grc, IncPC, Read, Write, Run;
  logic [4:0]  ALU_op;
  logic [3:0]  o_state;

  int total = 0;
  int bad   = 0;

  logic [24:0] exp_q[$];
  logic [24:0] ctl;

  // Strobe bit positions in the packed ctl vector
  localparam logic [24:0] B_RUN     = 25'd1 << 0;
  localparam logic [24:0] B_WRITE   = 25'd1 << 6;
  localparam logic [24:0] B_READ    = 25'd1 << 7;
  localparam logic [24:0] B_INCPC   = 25'd1 << 8;
  localparam logic [24:0] B_GRC     = 25'd1 << 9;
  localparam logic [24:0] B_GRB     = 25'd1 << 10;
  localparam logic [24:0] B_GRA     = 25'd1 << 11;
  localparam logic [24:0] B_ROUT    = 25'd1 << 12;
  localparam logic [24:0] B_RIN     = 25'd1 << 13;
  localparam logic [24:0] B_ZIN     = 25'd1 << 14;
  localparam logic [24:0] B_YIN     = 25'd1 << 15;
  localparam logic [24:0] B_IRIN    = 25'd1 << 16;
  localparam logic [24:0] B_MDRIN   = 25'd1 << 17;
  localparam logic [24:0] B_MARIN   = 25'd1 << 18;
  localparam logic [24:0] B_PCIN    = 25'd1 << 19;
  localparam logic [24:0] B_COUT    = 25'd1 << 20;
  localparam logic [24:0] B_BAOUT   = 25'd1 << 21;
  localparam logic [24:0] B_MDROUT  = 25'd1 << 22;
  localparam logic [24:0] B_ZLOWOUT = 25'd1 << 23;
  localparam logic [24:0] B_PCOUT   = 25'd1 << 24;

  localparam logic [3:0] ST_RST  = 4'd0;
  localparam logic [3:0] ST_T0   = 4'd1;
  localparam logic [3:0] ST_HALT = 4'd9;

  assign ctl = {PCout, Zlowout, MDRout, BAout, Cout, PCin, MARin, MDRin, IRin,
                Yin, Zin, Rin, Rout, Gra, Grb, Grc, IncPC, Read, Write, ALU_op, Run};

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .BAout(BAout), .Cout(Cout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Rin(Rin), .Rout(Rout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC),
    .Read(Read), .Write(Write), .ALU_op(ALU_op), .Run(Run), .o_state(o_state)
  );

  // Clock and watchdog
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [24:0] alu(input logic [4:0] op);
    return {19'd0, op, 1'b0};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_fetch();
    exp_q.push_back(B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN);
    exp_q.push_back(B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN | B_RUN);
    exp_q.push_back(B_MDROUT | B_IRIN | B_RUN);
  endtask

  // Address-form T3/T4 shared by ldi, ld and st
  task automatic push_addr_t3_t4();
    exp_q.push_back(B_GRB | B_BAOUT | B_YIN | B_RUN);
    exp_q.push_back(B_COUT | B_ZIN | alu(5'b00011) | B_RUN);
  endtask

  task automatic push_reg_op(input logic [4:0] op);
    push_fetch();
    exp_q.push_back(B_GRB | B_ROUT | B_YIN | B_RUN);
    exp_q.push_back(B_GRC | B_ROUT | B_ZIN | alu(op) | B_RUN);
    exp_q.push_back(B_ZLOWOUT | B_GRA | B_RIN | B_RUN);
  endtask

  task automatic push_imm_op(input logic [4:0] op);
    push_fetch();
    exp_q.push_back(B_GRB | B_ROUT | B_YIN | B_RUN);
    exp_q.push_back(B_COUT | B_ZIN | alu(op) | B_RUN);
    exp_q.push_back(B_ZLOWOUT | B_GRA | B_RIN | B_RUN);
  endtask

  // Step one cycle per queued vector starting in T0; Stop high only in cycle stop_idx
  task automatic drain(input string tag, input logic [31:0] ir, input int stop_idx);
    int n;
    IR = ir;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      Stop = (i == stop_idx);
      check_val($sformatf("%s_c%0d", tag, i), {7'd0, ctl}, {7'd0, exp_q.pop_front()});
      tick();
    end
    Stop = 1'b0;
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    tick();
    check_val("rst_state", {28'd0, o_state}, {28'd0, ST_RST});
    check_val("rst_ctl", {7'd0, ctl}, 32'd0);
    Reset = 1'b0;
    tick();
    check_val("rst_exit_t0", {28'd0, o_state}, {28'd0, ST_T0});
  endtask

  initial begin
    Reset = 1'b1;
    Stop  = 1'b0;
    IR    = 32'd0;
    tick();
    tick();
    check_val("por_state", {28'd0, o_state}, {28'd0, ST_RST});
    check_val("por_ctl", {7'd0, ctl}, 32'd0);
    Reset = 1'b0;
    tick();
    check_val("por_t0", {28'd0, o_state}, {28'd0, ST_T0});

    // and R5,R2,R4
    push_reg_op(5'b01001);
    drain("and", 32'h4A920000, -1);
    check_val("and_back_t0", {28'd0, o_state}, {28'd0, ST_T0});

    // ldi R2,0x95
    push_fetch();
    push_addr_t3_t4();
    exp_q.push_back(B_ZLOWOUT | B_GRA | B_RIN | B_RUN);
    drain("ldi", 32'h09000095, -1);
    check_val("ldi_back_t0", {28'd0, o_state}, {28'd0, ST_T0});

    // ld R1,0x54(R2)
    push_fetch();
    push_addr_t3_t4();
    exp_q.push_back(B_ZLOWOUT | B_MARIN | B_RUN);
    exp_q.push_back(B_READ | B_MDRIN | B_RUN);
    exp_q.push_back(B_MDROUT | B_GRA | B_RIN | B_RUN);
    drain("ld", 32'h00900054, -1);
    check_val("ld_back_t0", {28'd0, o_state}, {28'd0, ST_T0});

    // st R3,0x20(R4)
    push_fetch();
    push_addr_t3_t4();
    exp_q.push_back(B_ZLOWOUT | B_MARIN | B_RUN);
    exp_q.push_back(B_GRA | B_ROUT | B_MDRIN | B_RUN);
    exp_q.push_back(B_WRITE | B_RUN);
    drain("st", 32'h11A00020, -1);
    check_val("st_back_t0", {28'd0, o_state}, {28'd0, ST_T0});

    // Other R-type and immediate mappings
    push_reg_op(5'b00100);
    drain("sub", 32'h20000000, -1);
    push_reg_op(5'b01000);
    drain("rol", 32'h40000000, -1);
    push_imm_op(5'b00011);
    drain("addi", 32'h58000000, -1);
    push_imm_op(5'b01001);
    drain("andi", 32'h60000000, -1);
    push_imm_op(5'b01010);
    drain("ori", 32'h68000000, -1);

    // nop and an undefined opcode both take four cycles
    push_fetch();
    exp_q.push_back(B_RUN);
    drain("nop", 32'hD0000000, -1);
    check_val("nop_back_t0", {28'd0, o_state}, {28'd0, ST_T0});
    push_fetch();
    exp_q.push_back(B_RUN);
    drain("undef", 32'hF8000000, -1);
    check_val("undef_back_t0", {28'd0, o_state}, {28'd0, ST_T0});

    // Stop sampled in T5 of an add
    push_reg_op(5'b00011);
    drain("add_stop", 32'h18000000, 5);
    check_val("stop_halt", {28'd0, o_state}, {28'd0, ST_HALT});
    check_val("stop_halt_ctl", {7'd0, ctl}, 32'd0);
    tick();
    check_val("halt_held", {28'd0, o_state}, {28'd0, ST_HALT});
    apply_reset();

    // halt instruction
    push_fetch();
    exp_q.push_back(B_RUN);
    drain("halt", 32'hD8000000, -1);
    check_val("halt_state", {28'd0, o_state}, {28'd0, ST_HALT});
    check_val("halt_run", {31'd0, Run}, 32'd0);
    apply_reset();

    // Reset during T4 of an ld
    push_fetch();
    push_addr_t3_t4();
    void'(exp_q.pop_back());
    drain("ld_abort", 32'h00900054, -1);
    check_val("ld_abort_t4", {7'd0, ctl}, {7'd0, B_COUT | B_ZIN | alu(5'b00011) | B_RUN});
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("abort_state_%0d", i), {28'd0, o_state}, {28'd0, ST_RST});
      check_val($sformatf("abort_ctl_%0d", i), {7'd0, ctl}, 32'd0);
    end
    Reset = 1'b0;
    tick();
    check_val("abort_t0", {7'd0, ctl}, {7'd0, B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer that sits directly upstream of `datapath`. It steps through the fetch states T0–T2, then through the execute states T3–T7 for the instruction held in IR. Each cycle it drives the datapath's register-transfer control strobes: bus-out enables, register-in enables, ALU op, Read/Write, and the Gra/Grb/Grc register selects. It replaces the hand-scripted stimulus sequence used for bring-up, so the CPU can run programs from memory autonomously.

## Interface
- No parameters. The field layout is fixed at 32 bits: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- IR  in  32  instruction register contents from datapath; valid from T3 onward.
- Stop  in  1  request to halt after the current instruction completes.
- PCout, Zlowout, MDRout, BAout, Cout  out  1 each  bus-driver enables.
- PCin, MARin, MDRin, IRin, Yin, Zin, Rin  out  1 each  register load enables.
- Rout  out  1  enables the register selected by Gra/Grb/Grc onto the bus.
- Gra, Grb, Grc  out  1 each  select the Ra/Rb/Rc field for Rin/Rout/BAout.
- IncPC  out  1  ALU computes PC+1.
- Read, Write  out  1 each  memory strobes.
- ALU_op  out  5  operation code to ALU; 5'b00000 = none.
- Run  out  1  high while executing; low in RST and HALT.

## Operation
- States: RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT.
- Supported opcodes:
  - ld 00000, ldi 00001, st 00010.
  - add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010.
  - addi 01011, andi 01100, ori 01101.
  - nop 11010, halt 11011.
  - Any other opcode executes as nop.
- Fetch:
  - T0: PCout MARin IncPC Zin.
  - T1: Zlowout PCin Read MDRin.
  - T2: MDRout IRin.
- R-type (add..or):
  - T3: Grb Rout Yin.
  - T4: Grc Rout Zin, ALU_op=opcode.
  - T5: Zlowout Gra Rin, then T0.
- Immediate (addi/andi/ori):
  - T3: Grb Rout Yin.
  - T4: Cout Zin, ALU_op = add/and/or code respectively.
  - T5: Zlowout Gra Rin, then T0.
- ldi:
  - T3: Grb BAout Yin.
  - T4: Cout Zin, ALU_op=add.
  - T5: Zlowout Gra Rin, then T0.
- ld:
  - T3–T4 as for ldi.
  - T5: Zlowout MARin.
  - T6: Read MDRin.
  - T7: MDRout Gra Rin, then T0.
- st:
  - T3–T4 as for ldi.
  - T5: Zlowout MARin.
  - T6: Gra Rout MDRin (Read=0, so MDR loads from the bus).
  - T7: Write, then T0.
- nop: T3 asserts nothing, then T0.
- halt: T3 asserts nothing, then HALT. HALT is held until Reset.
- Stop is sampled in the final execute state of each instruction. If high, the next state is HALT instead of T0.
- Every output not listed for a state is 0. At most one of Gra/Grb/Grc is high in any state.

## Timing
- State register updates on posedge Clock. All outputs are pure combinational decodes of (state, IR[31:27]), so outputs are valid for the full cycle of their state.
- IR is loaded at the end of T2. Opcode decode is used only in T3–T7.
- Reset high at any edge: next state is RST, regardless of the current state, including mid-instruction or HALT.
- In RST all outputs are 0, Run=0, ALU_op=0.
- First edge with Reset low: RST goes to T0, Run=1.
- Instruction lengths in cycles: R-type, immediate, and ldi take 6; ld and st take 8; nop takes 4; halt takes 4 plus HALT.
- Run=1 in T0–T7, 0 in RST and HALT.

## Structure
- Shared package `cpu_defs_pkg` holds:
  - opcode constants (OP_LD … OP_HALT);
  - the state encoding (4-bit: RST=0, T0..T7=1..8, HALT=9);
  - IR field bit positions.
- Sub-module `instr_decode` is combinational and maps an opcode to a one-hot class (rtype, imm, ldi, ld, st, nop, halt) plus the mapped ALU_op.
- `control_unit` contains the state register, next-state logic, and the output decode.

## Test plan
- Reset, then IR=0x4A920000 (and R5,R2,R4) during T3:
  - T0–T5 strobes occur exactly in the fetch/R-type order.
  - T4 has Grc=1, Rout=1, ALU_op=01001.
  - T5 has Gra=1, Rin=1.
  - Back in T0 at cycle 7.
- IR=0x09000095 (ldi R2,0x95):
  - T3 has BAout=1, Grb=1.
  - T4 has Cout=1, ALU_op=00011.
  - T5 has Gra Rin.
  - Length is 6 cycles.
- IR=0x00900054 (ld R1,0x54(R2)):
  - T5 has MARin.
  - T6 has Read MDRin.
  - T7 has MDRout Gra Rin.
  - Returns to T0 after 8 cycles.
- IR=0x11A00020 (st R3,0x20(R4)):
  - T6 has Gra Rout MDRin with Read=0.
  - T7 has Write=1 and all else 0.
- IR=0xD8000000 (halt): HALT is entered after T3 and Run=0. Stop pulsed during an add leads to HALT after T5. Reset then gives RST, then T0.
- Reset asserted during T4 of an ld: the next cycle is RST with all outputs 0, and no Write or Rin occurs.
